alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the lab ALU. It keeps the same 16-opcode set and the same Cout semantics. It adds four things:
- a `WIDTH` parameter;
- a variable shift amount taken from B, executed iteratively at one bit per cycle;
- valid/ready handshakes on input and output;
- a registered Zero flag.

It sits between an operand-issue stage and a writeback stage in the lab datapath.

---
 rtl/alu_multicycle.sv | 173 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: 16 opcodes, registered C/Cout/Zero, and variable
// shifts executed one bit per cycle from a work register and down-counter.

module alu_multicycle #(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Cout,
    output logic             Zero,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds its data until then and ready never depends
    // on valid on the same side.

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_NAND = 4'h4, OP_NOR  = 4'h5, OP_XOR = 4'h6, OP_XNOR = 4'h7,
        OP_ID   = 4'h8, OP_NOT  = 4'h9, OP_LRS = 4'hA, OP_ARS = 4'hB,
        OP_RR   = 4'hC, OP_LLS  = 4'hD, OP_ALS = 4'hE, OP_RL   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   c_q;
    logic               cout_q, zero_q;
    logic [WIDTH-1:0]   work_q, work_next;
    logic [SHAMT_W-1:0] cnt_q;
    op_e                sop_q;

    op_e                op_in;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   alu_c, sum, diff;
    logic               alu_cout;
    logic               load_alu, start_shift, shift_en, shift_last;

    assign op_in    = op_e'(OP);
    assign shamt    = B[SHAMT_W-1:0];
    assign is_shift = (OP >= 4'hA);
    assign sum      = A + B;
    assign diff     = A - B;

    // Single-bit step of the captured shift opcode.
    function automatic logic [WIDTH-1:0] shift_one(input op_e op, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        case (op)
            OP_LRS:         r = {1'b0, v[WIDTH-1:1]};
            OP_ARS:         r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_RR:          r = {v[0], v[WIDTH-1:1]};
            OP_LLS, OP_ALS: r = {v[WIDTH-2:0], 1'b0};
            OP_RL:          r = {v[WIDTH-2:0], v[WIDTH-1]};
            default:        r = v;
        endcase
        return r;
    endfunction

    assign work_next = shift_one(sop_q, work_q);

    always_comb begin
        alu_c    = '0;
        alu_cout = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_c    = sum;
                alu_cout = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_c    = diff;
                alu_cout = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_c = A & B;
            OP_OR:   alu_c = A | B;
            OP_NAND: alu_c = ~(A & B);
            OP_NOR:  alu_c = ~(A | B);
            OP_XOR:  alu_c = A ^ B;
            OP_XNOR: alu_c = ~(A ^ B);
            OP_NOT:  alu_c = ~A;
            // ID and zero-length shifts both pass A straight through.
            default: alu_c = A;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        load_alu    = 1'b0;
        start_shift = 1'b0;
        shift_en    = 1'b0;
        shift_last  = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    shift_last = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) in_ready = 1'b0;
        // An accept overrides the retire-to-idle transition for back-to-back ops.
        if (in_valid && in_ready) begin
            if (is_shift && (shamt != '0)) begin
                start_shift = 1'b1;
                state_d     = S_SHIFT;
            end else begin
                load_alu = 1'b1;
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            sop_q   <= OP_ADD;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                c_q    <= alu_c;
                cout_q <= alu_cout;
                zero_q <= (alu_c == '0);
            end else if (shift_last) begin
                c_q    <= work_next;
                cout_q <= 1'b0;
                zero_q <= (work_next == '0);
            end
            if (start_shift) begin
                work_q <= A;
                cnt_q  <= shamt;
                sop_q  <= op_in;
            end else if (shift_en) begin
                work_q <= work_next;
                cnt_q  <= cnt_q - SHAMT_W'(1);
            end
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign C         = c_q;
    assign Cout      = cout_q;
    assign Zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases on 16- and 32-bit instances plus a
// randomized handshake run scored against a closed-form reference model.

module tb_alu_multicycle;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, c16;
    logic [3:0]  op16;
    logic        cout16, zero16;
    logic [1:0]  dbg16;

    // 32-bit instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, c32;
    logic [3:0]  op32;
    logic        cout32, zero32;
    logic [1:0]  dbg32;

    alu_multicycle #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .OP(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .C(c16), .Cout(cout16), .Zero(zero16), .dbg_state(dbg16)
    );

    alu_multicycle #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a32), .B(b32), .OP(op32), .out_valid(out_valid32), .out_ready(out_ready32),
        .C(c32), .Cout(cout32), .Zero(zero32), .dbg_state(dbg32)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_c(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        int          n;
        m = (64'd1 << w) - 64'd1;
        a = a & m;
        b = b & m;
        n = int'(b % 64'(w));
        case (op)
            4'h0: return (a + b) & m;
            4'h1: return (a - b) & m;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return ~(a & b) & m;
            4'h5: return ~(a | b) & m;
            4'h6: return a ^ b;
            4'h7: return ~(a ^ b) & m;
            4'h8: return a;
            4'h9: return ~a & m;
            4'hA: return a >> n;
            4'hB: return (a >> n) | (a[w-1] ? (m & ~(m >> n)) : 64'd0);
            4'hC: return (n == 0) ? a : (((a >> n) | (a << (w - n))) & m);
            4'hD, 4'hE: return (a << n) & m;
            default: return (n == 0) ? a : (((a << n) | (a >> (w - n))) & m);
        endcase
    endfunction

    function automatic logic ref_cout(input int w, input logic [3:0] op,
                                      input logic [63:0] a, input logic [63:0] b);
        logic [63:0] c;
        c = ref_c(w, op, a, b);
        if (op == 4'h0) return (a[w-1] == b[w-1]) && (c[w-1] != a[w-1]);
        if (op == 4'h1) return (a[w-1] != b[w-1]) && (c[w-1] != a[w-1]);
        return 1'b0;
    endfunction

    // ---------------- scoreboard (16-bit instance) ----------------
    logic [16:0] exp_q[$];
    logic [16:0] exp_e;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid16 && out_ready16) begin
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("sb_c", c16, exp_e[15:0]);
                    check("sb_cout", cout16, exp_e[16]);
                    check("sb_zero", zero16, exp_e[15:0] == 16'h0);
                end
            end
            if (in_valid16 && in_ready16)
                exp_q.push_back({ref_cout(16, op16, a16, b16), ref_c(16, op16, a16, b16)[15:0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] rc, output logic rcout, output logic rzero,
                           output int lat);
        op16 = o; a16 = x; b16 = y; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom);
        lat = 1;
        while (!out_valid16 && lat < 40) begin
            tick();
            lat++;
        end
        rc = c16; rcout = cout16; rzero = zero16;
        tick();
    endtask

    task automatic directed16(input string tag, input logic [3:0] o, input logic [15:0] x,
                              input logic [15:0] y, input logic [15:0] ec, input logic ecout,
                              input int elat);
        logic [15:0] rc;
        logic        rcout, rzero;
        int          lat;
        issue16(o, x, y, rc, rcout, rzero, lat);
        check({tag, "_c"}, rc, ec);
        check({tag, "_cout"}, rcout, ecout);
        check({tag, "_zero"}, rzero, ec == 16'h0);
        if (elat > 0) check({tag, "_lat"}, lat, elat);
    endtask

    task automatic directed32(input string tag, input logic [3:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] ec, input logic ecout,
                              input int elat);
        int lat;
        op32 = o; a32 = x; b32 = y; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        lat = 1;
        while (!out_valid32 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_c"}, c32, ec);
        check({tag, "_model"}, c32, ref_c(32, o, x, y));
        check({tag, "_cout"}, cout32, ecout);
        check({tag, "_zero"}, zero32, ec == 32'h0);
        check({tag, "_lat"}, lat, elat);
        tick();
    endtask

    logic fired16;

    task automatic drive_cycle();
        @(negedge clk);
        fired16 = in_valid16 && in_ready16;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        reset = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
        fired16 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready16, 0);
        check("rst_out_valid", out_valid16, 0);
        check("rst_c", c16, 0);
        check("rst_cout", cout16, 0);
        check("rst_zero", zero16, 0);
        check("rst_out_valid32", out_valid32, 0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", in_ready16, 1);

        // ADD corner cases
        directed16("add_ovf", 4'h0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1);
        directed16("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1);

        // back-to-back with out_ready held high
        op16 = 4'h1; a16 = 16'h0000; b16 = 16'hFFFF; in_valid16 = 1'b1;
        check("b2b_ready0", in_ready16, 1);
        tick();
        check("b2b_c0", c16, 16'h0001);
        check("b2b_ready1", in_ready16, 1);
        op16 = 4'h0; a16 = 16'h0002; b16 = 16'h0003;
        tick();
        check("b2b_c1", c16, 16'h0005);
        check("b2b_ready2", in_ready16, 1);
        op16 = 4'h9; a16 = 16'hCAFE;
        tick();
        in_valid16 = 1'b0;
        check("b2b_c2", c16, 16'h3501);
        check("b2b_valid2", out_valid16, 1);
        tick();
        check("b2b_idle", out_valid16, 0);

        // variable shifts
        directed16("rr1", 4'hC, 16'h000B, 16'd1, 16'h8005, 1'b0, 2);
        directed16("lrs4", 4'hA, 16'hFFFA, 16'd4, 16'h0FFF, 1'b0, 5);
        directed16("ars3", 4'hB, 16'hFFFA, 16'd3, 16'hFFFF, 1'b0, 4);
        directed16("rl1", 4'hF, 16'hF000, 16'd1, 16'hE001, 1'b0, 2);
        directed16("lls0", 4'hD, 16'h1234, 16'd0, 16'h1234, 1'b0, 1);
        directed16("als15", 4'hE, 16'h0003, 16'd15, 16'h8000, 1'b0, 16);

        // backpressure, then same-cycle handoff to a pending ADD
        out_ready16 = 1'b0;
        op16 = 4'h6; a16 = 16'h7777; b16 = 16'h5555; in_valid16 = 1'b1;
        tick();
        op16 = 4'h0; a16 = 16'h0001; b16 = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            check("bp_c", c16, 16'h2222);
            check("bp_valid", out_valid16, 1);
            check("bp_in_ready", in_ready16, 0);
            tick();
        end
        check("bp_c_held", c16, 16'h2222);
        out_ready16 = 1'b1;
        #1;
        check("bp_release_ready", in_ready16, 1);
        tick();
        in_valid16 = 1'b0;
        check("handoff_c", c16, 16'h0002);
        check("handoff_valid", out_valid16, 1);
        tick();
        check("handoff_idle", out_valid16, 0);

        // reset in the middle of a long rotate
        op16 = 4'hF; a16 = 16'h0001; b16 = 16'd10; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        seen = out_valid16;
        tick();
        seen |= out_valid16;
        tick();
        seen |= out_valid16;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready16, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_c", c16, 0);
        check("mid_rst_valid", out_valid16, 0);
        check("mid_rst_in_ready_after", in_ready16, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            seen |= out_valid16;
        end
        check("mid_rst_no_valid", seen, 0);

        // WIDTH=32 instance
        directed32("w32_add", 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1);
        directed32("w32_ars31", 4'hB, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 32);

        // randomized traffic with random backpressure
        fired16 = 1'b0;
        in_valid16 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            out_ready16 = ($urandom_range(0, 3) != 0);
            if (!in_valid16 || fired16) begin
                in_valid16 = ($urandom_range(0, 2) != 0);
                op16 = 4'($urandom);
                a16  = 16'($urandom);
                b16  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            end
            drive_cycle();
        end
        if (fired16 || !in_valid16) in_valid16 = 1'b0;
        while (in_valid16) begin
            out_ready16 = 1'b1;
            drive_cycle();
            if (fired16) in_valid16 = 1'b0;
            if (n_checks > 100000) in_valid16 = 1'b0;
        end
        out_ready16 = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", out_valid16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
